// File: rtl/fetch_mem_unit.sv
// fetch_mem_unit: program counter, unified word-addressed memory, instruction
// register and memory data register of a multi-cycle processor datapath.
// Memory reads are combinational; all registers update on the rising clock edge.
// The registers reset asynchronously on rst low. Memory contents survive reset.
module fetch_mem_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          DEPTH_LOG2 = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        IorD,
    input  logic        PCSrc,
    input  logic        PCWrite,
    input  logic        IRWrite,
    input  logic        MemWrite,
    input  logic [31:0] alu_result,
    input  logic [31:0] alu_out,
    input  logic [31:0] write_data,
    output logic [31:0] pc,
    output logic [31:0] instr,
    output logic [31:0] mem_data,
    output logic [5:0]  opcode,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [4:0]  shamt,
    output logic [5:0]  func,
    output logic [15:0] imm16,
    output logic        access_err,
    output logic [15:0] fetch_count
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    // Unified instruction/data storage, one 32-bit word per entry
    logic [31:0] mem [0:DEPTH-1];

    logic [31:0]           addr;
    logic                  addr_legal;
    logic [DEPTH_LOG2-1:0] word_idx;
    logic [31:0]           rd_word;
    logic                  mem_we;

    logic [31:0] pc_q,     pc_d;
    logic [31:0] instr_q,  instr_d;
    logic [31:0] mdr_q,    mdr_d;
    logic        err_q,    err_d;
    logic [15:0] fcount_q, fcount_d;

    // Address selection, legality check and combinational memory read.
    // A legal address is word aligned and falls inside the memory depth.
    always_comb begin
        addr       = IorD ? alu_out : pc_q;
        addr_legal = (addr[1:0] == 2'b00) &&
                     ((addr >> (DEPTH_LOG2 + 2)) == 32'd0);
        word_idx   = addr[DEPTH_LOG2+1:2];
        rd_word    = addr_legal ? mem[word_idx] : 32'h0000_0000;
        mem_we     = MemWrite && addr_legal;
    end

    // Next-state logic for the PC, IR, MDR, error flag and fetch counter
    always_comb begin
        pc_d     = pc_q;
        instr_d  = instr_q;
        mdr_d    = rd_word;
        err_d    = err_q;
        fcount_d = fcount_q;
        if (PCWrite) begin
            // Loaded unmodified; a misaligned target is caught on the next access
            pc_d = PCSrc ? alu_out : alu_result;
        end
        if (IRWrite) begin
            instr_d = rd_word;
            if (fcount_q != 16'hFFFF) begin
                fcount_d = fcount_q + 16'd1;
            end
        end
        if ((IRWrite || MemWrite) && !addr_legal) begin
            err_d = 1'b1;
        end
    end

    // Register update with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q     <= RESET_PC;
            instr_q  <= 32'h0000_0000;
            mdr_q    <= 32'h0000_0000;
            err_q    <= 1'b0;
            fcount_q <= 16'h0000;
        end else begin
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            mdr_q    <= mdr_d;
            err_q    <= err_d;
            fcount_q <= fcount_d;
        end
    end

    // Memory write; gated by rst so a reset asserted mid-cycle cancels the store.
    // Reads in the same cycle see the old word because the read path is
    // sampled by IR/MDR at the same edge that commits the write.
    always_ff @(posedge clk) begin
        if (rst && mem_we) begin
            mem[word_idx] <= write_data;
        end
    end

    // Outputs and instruction field slices
    always_comb begin
        pc          = pc_q;
        instr       = instr_q;
        mem_data    = mdr_q;
        access_err  = err_q;
        fetch_count = fcount_q;
        opcode      = instr_q[31:26];
        rs          = instr_q[25:21];
        rt          = instr_q[20:16];
        rd          = instr_q[15:11];
        shamt       = instr_q[10:6];
        func        = instr_q[5:0];
        imm16       = instr_q[15:0];
    end

endmodule

// File: tb/tb_fetch_mem_unit.sv
// tb_fetch_mem_unit: directed-vector bench for fetch_mem_unit. Inputs change
// 1 time unit after a rising edge; outputs are checked at the same point.
module tb_fetch_mem_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        IorD = 1'b0;
    logic        PCSrc = 1'b0;
    logic        PCWrite = 1'b0;
    logic        IRWrite = 1'b0;
    logic        MemWrite = 1'b0;
    logic [31:0] alu_result = '0;
    logic [31:0] alu_out = '0;
    logic [31:0] write_data = '0;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] mem_data;
    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  func;
    logic [15:0] imm16;
    logic        access_err;
    logic [15:0] fetch_count;

    int vectors = 0;
    int miscompares = 0;

    fetch_mem_unit #(
        .RESET_PC   (32'h0000_0000),
        .DEPTH_LOG2 (6)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .IorD        (IorD),
        .PCSrc       (PCSrc),
        .PCWrite     (PCWrite),
        .IRWrite     (IRWrite),
        .MemWrite    (MemWrite),
        .alu_result  (alu_result),
        .alu_out     (alu_out),
        .write_data  (write_data),
        .pc          (pc),
        .instr       (instr),
        .mem_data    (mem_data),
        .opcode      (opcode),
        .rs          (rs),
        .rt          (rt),
        .rd          (rd),
        .shamt       (shamt),
        .func        (func),
        .imm16       (imm16),
        .access_err  (access_err),
        .fetch_count (fetch_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        PCWrite  = 1'b0;
        IRWrite  = 1'b0;
        MemWrite = 1'b0;
    endtask

    initial begin
        // Reset and memory preload
        #1 rst = 1'b0;
        dut.mem[0] = 32'h2008_0005;
        dut.mem[1] = 32'hAAAA_5555;
        dut.mem[2] = 32'h0000_0000;
        dut.mem[3] = 32'h1111_1111;
        dut.mem[4] = 32'h0123_4567;
        dut.mem[63] = 32'h0000_0000;
        #1;
        chk("rst_pc", pc, 32'h0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_mdr", mem_data, 32'h0);
        chk("rst_err", {31'd0, access_err}, 32'h0);
        chk("rst_fcount", {16'd0, fetch_count}, 32'h0);
        tick();
        tick();
        rst = 1'b1;

        // Normal fetch cycle: IR takes word at old pc, pc advances
        IorD = 1'b0; IRWrite = 1'b1; PCWrite = 1'b1; PCSrc = 1'b0; alu_result = 32'd4;
        tick();
        chk("fetch_instr", instr, 32'h2008_0005);
        chk("fetch_opcode", {26'd0, opcode}, 32'h08);
        chk("fetch_rt", {27'd0, rt}, 32'd8);
        chk("fetch_imm16", {16'd0, imm16}, 32'd5);
        chk("fetch_pc", pc, 32'd4);
        chk("fetch_count1", {16'd0, fetch_count}, 32'd1);
        chk("fetch_mdr", mem_data, 32'h2008_0005);
        idle();

        // PC from alu_out, misaligned value loaded unmodified, then hold
        PCWrite = 1'b1; PCSrc = 1'b1; alu_out = 32'h0000_0003; alu_result = 32'h0000_0020;
        tick();
        chk("pc_alu_out_misaligned", pc, 32'h0000_0003);
        PCWrite = 1'b0; alu_out = 32'h0000_0044; alu_result = 32'h0000_0048;
        tick();
        chk("pc_hold", pc, 32'h0000_0003);
        chk("no_err_without_access", {31'd0, access_err}, 32'h0);
        PCWrite = 1'b1; PCSrc = 1'b0; alu_result = 32'd8;
        tick();
        chk("pc_alu_result", pc, 32'd8);
        idle();

        // Store then load through MDR
        IorD = 1'b1; alu_out = 32'd8; write_data = 32'hDEAD_BEEF; MemWrite = 1'b1;
        tick();
        MemWrite = 1'b0;
        tick();
        chk("load_mdr", mem_data, 32'hDEAD_BEEF);
        chk("store_no_err", {31'd0, access_err}, 32'h0);
        chk("instr_hold", instr, 32'h2008_0005);

        // Read-during-write with IRWrite while IorD=1
        alu_out = 32'd12; write_data = 32'h2222_2222; MemWrite = 1'b1; IRWrite = 1'b1;
        tick();
        chk("rdw_instr_old", instr, 32'h1111_1111);
        chk("rdw_mdr_old", mem_data, 32'h1111_1111);
        chk("rdw_fcount", {16'd0, fetch_count}, 32'd2);
        idle();
        tick();
        chk("rdw_mdr_new", mem_data, 32'h2222_2222);

        // Field slicing on a mixed pattern
        alu_out = 32'd16; IRWrite = 1'b1;
        tick();
        idle();
        chk("fld_opcode", {26'd0, opcode}, 32'd0);
        chk("fld_rs", {27'd0, rs}, 32'd9);
        chk("fld_rt", {27'd0, rt}, 32'd3);
        chk("fld_rd", {27'd0, rd}, 32'd8);
        chk("fld_shamt", {27'd0, shamt}, 32'd21);
        chk("fld_func", {26'd0, func}, 32'd39);
        chk("fld_imm16", {16'd0, imm16}, 32'h4567);

        // Top legal word
        alu_out = 32'h0000_00FC; write_data = 32'h5A5A_A5A5; MemWrite = 1'b1;
        tick();
        MemWrite = 1'b0;
        tick();
        chk("top_word", mem_data, 32'h5A5A_A5A5);
        chk("top_word_no_err", {31'd0, access_err}, 32'h0);

        // Illegal accesses: misaligned and out-of-range writes suppressed
        alu_out = 32'h0000_0006; write_data = 32'hFFFF_FFFF; MemWrite = 1'b1;
        tick();
        chk("misaligned_err", {31'd0, access_err}, 32'h1);
        alu_out = 32'h0000_0104;
        tick();
        MemWrite = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        chk("err_sticky", {31'd0, access_err}, 32'h1);
        alu_out = 32'd4;
        tick();
        chk("illegal_write_suppressed", mem_data, 32'hAAAA_5555);
        alu_out = 32'h0000_0100;
        tick();
        chk("out_of_range_read", mem_data, 32'h0);

        // Build pc=0x40, fetch_count=7, then async reset mid-cycle
        PCWrite = 1'b1; PCSrc = 1'b0; alu_result = 32'h0000_0040;
        IorD = 1'b1; alu_out = 32'd0; IRWrite = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        idle();
        chk("pre_rst_pc", pc, 32'h0000_0040);
        chk("pre_rst_fcount", {16'd0, fetch_count}, 32'd7);
        alu_out = 32'd8; write_data = 32'hBAD0_BAD0; MemWrite = 1'b1;
        #2 rst = 1'b0;
        #1;
        chk("async_pc", pc, 32'h0);
        chk("async_instr", instr, 32'h0);
        chk("async_mdr", mem_data, 32'h0);
        chk("async_err", {31'd0, access_err}, 32'h0);
        chk("async_fcount", {16'd0, fetch_count}, 32'h0);
        tick();
        chk("rst_held_pc", pc, 32'h0);
        #3 rst = 1'b1;
        MemWrite = 1'b0;
        tick();
        chk("rst_write_aborted", mem_data, 32'hDEAD_BEEF);

        // Fetch counter saturation
        alu_out = 32'd0; IRWrite = 1'b1;
        for (int i = 0; i < 65534; i++) @(posedge clk);
        #1;
        chk("fcount_fffe", {16'd0, fetch_count}, 32'h0000_FFFE);
        for (int i = 0; i < 3; i++) @(posedge clk);
        #1;
        chk("fcount_saturated", {16'd0, fetch_count}, 32'h0000_FFFF);
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
